// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the accumulator machine: instruction fields, opcodes,
// register codes and the fetch FSM encoding (also used by the control block).
package inst_fetch_pkg;

   localparam int INST_W = 32;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_DIV = 3'b010;
   localparam logic [2:0] OP_MUL = 3'b011;
   localparam logic [2:0] OP_MC  = 3'b100;
   localparam logic [2:0] OP_HLT = 3'b101;
   localparam logic [2:0] OP_MR  = 3'b110;
   localparam logic [2:0] OP_MW  = 3'b111;

   localparam int OPC_HI = 31;
   localparam int OPC_LO = 29;
   localparam int SRC_HI = 28;
   localparam int SRC_LO = 27;
   localparam int DST_HI = 26;
   localparam int DST_LO = 25;
   localparam int IMM_HI = 24;
   localparam int IMM_LO = 0;

   localparam logic [1:0] REG_A    = 2'b00;
   localparam logic [1:0] REG_B    = 2'b01;
   localparam logic [1:0] REG_ACC  = 2'b10;
   localparam logic [1:0] REG_ZERO = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_HALT  = 2'd3
   } fetch_state_t;

   function automatic logic [2:0] opcode_of(input logic [INST_W-1:0] word);
      return word[OPC_HI:OPC_LO];
   endfunction

endpackage

// File: rtl/inst_queue.sv
// Two-entry instruction prefetch FIFO. Simultaneous push and pop is legal at
// any occupancy; the head word only changes when it is popped.
module inst_queue
   import inst_fetch_pkg::*;
(
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              push,
   input  logic              pop,
   input  logic [INST_W-1:0] din,
   output logic [INST_W-1:0] head,
   output logic              full,
   output logic              empty,
   output logic [1:0]        count
);

   logic [INST_W-1:0] slots [2];
   logic              wr_ptr;
   logic              rd_ptr;
   logic              do_push;
   logic              do_pop;

   assign empty   = (count == 2'd0);
   assign full    = (count == 2'd2);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = slots[rd_ptr];

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (do_push) wr_ptr <= ~wr_ptr;
         if (do_pop)  rd_ptr <= ~rd_ptr;
         case ({do_push, do_pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   // Storage carries no reset: the head is only observed while the queue is non-empty.
   always_ff @(posedge CLK) begin
      if (do_push) slots[wr_ptr] <= din;
   end

   always_ff @(posedge CLK) begin
      if (RST_N) assert (!(push && full && !pop));
   end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: issues single-outstanding reads, buffers returned
// words in a 2-entry queue and stops fetching once an HLT word arrives.
module inst_fetch
   import inst_fetch_pkg::*;
#(
   parameter int unsigned       ADDR_W   = 25,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int unsigned       QDEPTH   = 2
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              start,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [INST_W-1:0] mem_rdata,
   input  logic              mem_rvalid,
   output logic [INST_W-1:0] inst,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [ADDR_W-1:0] pc,
   output logic              halted
);

   fetch_state_t      state;
   fetch_state_t      state_next;
   logic              outstanding;
   logic              issue;
   logic              push;
   logic              pop;
   logic              hlt_in;
   logic              hlt_out;
   logic [INST_W-1:0] q_head;
   logic              q_full;
   logic              q_empty;
   logic [1:0]        q_count;

   inst_queue u_queue (
      .CLK   (CLK),
      .RST_N (RST_N),
      .push  (push),
      .pop   (pop),
      .din   (mem_rdata),
      .head  (q_head),
      .full  (q_full),
      .empty (q_empty),
      .count (q_count)
   );

   // A slot is reserved at issue time, so a returning word always has room.
   assign issue = (state == ST_RUN) && !outstanding && !q_full
                  && (32'(q_count) < QDEPTH);

   // Data returning with nothing outstanding (e.g. after a reset) is dropped.
   assign push    = mem_rvalid && outstanding;
   assign pop     = inst_valid && inst_ready;
   assign hlt_in  = push && (opcode_of(mem_rdata) == OP_HLT);
   assign hlt_out = pop && (opcode_of(q_head) == OP_HLT);

   assign mem_req    = issue;
   assign mem_addr   = issue ? pc : '0;
   assign inst_valid = !q_empty && (state != ST_HALT);
   assign inst       = inst_valid ? q_head : '0;
   assign halted     = (state == ST_HALT);

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:  if (start)   state_next = ST_RUN;
         ST_RUN:   if (hlt_in)  state_next = ST_DRAIN;
         ST_DRAIN: if (hlt_out) state_next = ST_HALT;
         ST_HALT:  state_next = ST_HALT;
         default:  state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state       <= ST_IDLE;
         pc          <= RESET_PC;
         outstanding <= 1'b0;
      end else begin
         state <= state_next;
         if (issue) begin
            pc          <= pc + ADDR_W'(1);
            outstanding <= 1'b1;
         end else if (push) begin
            outstanding <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: a 25-bit instance and a 3-bit wrap-around
// instance, each with a 1-cycle memory model and a transfer scoreboard.
module tb_inst_fetch;
   import inst_fetch_pkg::*;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;

   logic        start = 1'b0;
   logic        mem_req;
   logic [24:0] mem_addr;
   logic [31:0] mem_rdata;
   logic        mem_rvalid;
   logic [31:0] inst;
   logic        inst_valid;
   logic        inst_ready = 1'b1;
   logic [24:0] pc;
   logic        halted;

   logic        start3 = 1'b0;
   logic        mem_req3;
   logic [2:0]  mem_addr3;
   logic [31:0] mem_rdata3;
   logic        mem_rvalid3;
   logic [31:0] inst3;
   logic        inst_valid3;
   logic        inst_ready3 = 1'b1;
   logic [2:0]  pc3;
   logic        halted3;

   logic [31:0] mem_a [16];
   logic [31:0] mem3 [8];
   logic        rv_m = 1'b0;
   logic [31:0] rd_m = '0;
   logic        rv3 = 1'b0;
   logic [31:0] rd3 = '0;
   logic        drop_en = 1'b0;
   logic        ovr = 1'b0;

   logic [24:0] req_q [$];
   logic [31:0] got_q [$];
   logic [2:0]  req3_q [$];
   logic [31:0] got3_q [$];
   logic [31:0] exp_q [$];
   logic [31:0] exp3_q [$];
   int          got_rd;
   int          got3_rd;
   int          cyc = 0;
   int          hlt_xfer_cyc = -1;
   int          halt_seen_cyc = -1;

   int          checks = 0;
   int          errors = 0;

   inst_fetch dut (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .start      (start),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_rdata  (mem_rdata),
      .mem_rvalid (mem_rvalid),
      .inst       (inst),
      .inst_valid (inst_valid),
      .inst_ready (inst_ready),
      .pc         (pc),
      .halted     (halted)
   );

   inst_fetch #(.ADDR_W(3), .RESET_PC(3'd6), .QDEPTH(2)) dut3 (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .start      (start3),
      .mem_req    (mem_req3),
      .mem_addr   (mem_addr3),
      .mem_rdata  (mem_rdata3),
      .mem_rvalid (mem_rvalid3),
      .inst       (inst3),
      .inst_valid (inst_valid3),
      .inst_ready (inst_ready3),
      .pc         (pc3),
      .halted     (halted3)
   );

   always #5 CLK = ~CLK;

   // Memory models: one-cycle read latency; address 2 can be made to never answer.
   always @(posedge CLK) begin
      rv_m <= mem_req && !(drop_en && mem_addr == 25'd2);
      rd_m <= mem_a[mem_addr[3:0]];
      rv3  <= mem_req3;
      rd3  <= mem3[mem_addr3];
   end

   assign mem_rvalid  = ovr ? 1'b1 : rv_m;
   assign mem_rdata   = ovr ? 32'hDEAD_BEEF : rd_m;
   assign mem_rvalid3 = rv3;
   assign mem_rdata3  = rd3;

   always @(posedge CLK) begin
      cyc <= cyc + 1;
      if (!RST_N) begin
         req_q.delete();
         got_q.delete();
         req3_q.delete();
         got3_q.delete();
         hlt_xfer_cyc  <= -1;
         halt_seen_cyc <= -1;
      end else begin
         if (mem_req) req_q.push_back(mem_addr);
         if (mem_req3) req3_q.push_back(mem_addr3);
         if (inst_valid3 && inst_ready3) got3_q.push_back(inst3);
         if (inst_valid && inst_ready) begin
            got_q.push_back(inst);
            if (inst[31:29] == 3'b101) hlt_xfer_cyc <= cyc;
         end
         if (halted && halt_seen_cyc < 0) halt_seen_cyc <= cyc;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RST_N  = 1'b0;
      start  = 1'b0;
      start3 = 1'b0;
      repeat (2) @(negedge CLK);
      RST_N   = 1'b1;
      got_rd  = 0;
      got3_rd = 0;
      @(negedge CLK);
   endtask

   task automatic pulse_start(input bit which);
      @(negedge CLK);
      if (which) start3 = 1'b1; else start = 1'b1;
      @(negedge CLK);
      start  = 1'b0;
      start3 = 1'b0;
   endtask

   // Pops n expected words and compares them with the next observed transfers.
   task automatic drain(input bit which, input int n, input string tag);
      logic [31:0] e;
      logic [31:0] o;
      for (int i = 0; i < n; i++) begin
         int t;
         t = 0;
         while (((which ? got3_q.size() : got_q.size()) <= (which ? got3_rd : got_rd)) && t < 200) begin
            @(negedge CLK);
            t++;
         end
         if (t >= 200) begin
            chk($sformatf("%s_timeout%0d", tag, i), 32'd0, 32'd1);
            return;
         end
         if (which) begin
            e = exp3_q.pop_front();
            o = got3_q[got3_rd];
            got3_rd++;
         end else begin
            e = exp_q.pop_front();
            o = got_q[got_rd];
            got_rd++;
         end
         chk($sformatf("%s_word%0d", tag, i), o, e);
      end
   endtask

   task automatic push_image();
      exp_q.push_back(32'h0000_0000);
      exp_q.push_back(32'h2000_0000);
      exp_q.push_back(32'h6000_0000);
      exp_q.push_back(32'hA000_0000);
   endtask

   initial begin
      int unstable;
      int t;
      for (int i = 0; i < 16; i++) mem_a[i] = 32'h0000_0000;
      mem_a[1] = 32'h2000_0000;
      mem_a[2] = 32'h6000_0000;
      mem_a[3] = 32'hA000_0000;
      for (int i = 0; i < 8; i++) mem3[i] = 32'hE000_0000;
      mem3[6] = 32'h0200_0011;
      mem3[7] = 32'h0C00_0022;
      mem3[0] = 32'h1200_0033;
      mem3[1] = 32'hA000_0001;
      got_rd  = 0;
      got3_rd = 0;

      // Reset state
      @(negedge CLK);
      chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
      chk("rst_mem_addr", {7'd0, mem_addr}, 32'd0);
      chk("rst_inst", inst, 32'd0);
      chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
      chk("rst_halted", {31'd0, halted}, 32'd0);
      chk("rst_pc", {7'd0, pc}, 32'd0);
      chk("rst_pc3", {29'd0, pc3}, 32'd6);
      @(negedge CLK);
      RST_N = 1'b1;

      // Idle without start
      repeat (10) @(negedge CLK);
      chk("idle_req_count", req_q.size(), 32'd0);
      chk("idle_pc", {7'd0, pc}, 32'd0);
      chk("idle_inst_valid", {31'd0, inst_valid}, 32'd0);
      chk("idle_halted", {31'd0, halted}, 32'd0);

      // Streaming fetch with inst_ready held high
      do_reset();
      inst_ready = 1'b1;
      push_image();
      pulse_start(1'b0);
      drain(1'b0, 4, "run");
      repeat (6) @(negedge CLK);
      chk("run_halted", {31'd0, halted}, 32'd1);
      chk("run_pc", {7'd0, pc}, 32'd4);
      chk("run_inst_valid", {31'd0, inst_valid}, 32'd0);
      chk("run_req_count", req_q.size(), 32'd4);
      for (int i = 0; i < 4 && i < req_q.size(); i++)
         chk($sformatf("run_req_addr%0d", i), {7'd0, req_q[i]}, i);
      chk("run_hlt_seen", {31'd0, hlt_xfer_cyc >= 0}, 32'd1);
      chk("run_halt_latency", halt_seen_cyc, hlt_xfer_cyc + 1);

      // Back-pressure: consumer stalled for 20 cycles
      do_reset();
      inst_ready = 1'b0;
      push_image();
      pulse_start(1'b0);
      repeat (5) @(negedge CLK);
      unstable = 0;
      for (int i = 0; i < 15; i++) begin
         if (!(inst_valid === 1'b1 && inst === 32'h0000_0000)) unstable++;
         @(negedge CLK);
      end
      chk("stall_unstable_cycles", unstable, 32'd0);
      chk("stall_req_count", req_q.size(), 32'd2);
      for (int i = 0; i < 2 && i < req_q.size(); i++)
         chk($sformatf("stall_req_addr%0d", i), {7'd0, req_q[i]}, i);
      chk("stall_no_transfer", got_q.size(), 32'd0);
      inst_ready = 1'b1;
      drain(1'b0, 4, "stall");
      repeat (4) @(negedge CLK);
      chk("stall_halted", {31'd0, halted}, 32'd1);
      chk("stall_pc", {7'd0, pc}, 32'd4);

      // Address wrap-around on the 3-bit instance
      do_reset();
      exp3_q.push_back(32'h0200_0011);
      exp3_q.push_back(32'h0C00_0022);
      exp3_q.push_back(32'h1200_0033);
      exp3_q.push_back(32'hA000_0001);
      pulse_start(1'b1);
      drain(1'b1, 4, "wrap");
      repeat (4) @(negedge CLK);
      chk("wrap_halted", {31'd0, halted3}, 32'd1);
      chk("wrap_pc", {29'd0, pc3}, 32'd2);
      chk("wrap_req_count", req3_q.size(), 32'd4);
      if (req3_q.size() >= 4) begin
         chk("wrap_req0", {29'd0, req3_q[0]}, 32'd6);
         chk("wrap_req1", {29'd0, req3_q[1]}, 32'd7);
         chk("wrap_req2", {29'd0, req3_q[2]}, 32'd0);
         chk("wrap_req3", {29'd0, req3_q[3]}, 32'd1);
      end

      // Reset with a read to address 2 outstanding and stale data arriving
      do_reset();
      inst_ready = 1'b1;
      drop_en    = 1'b1;
      pulse_start(1'b0);
      t = 0;
      while (req_q.size() < 3 && t < 100) begin
         @(negedge CLK);
         t++;
      end
      chk("abort_req_reached", {31'd0, t < 100}, 32'd1);
      @(negedge CLK);
      RST_N = 1'b0;
      ovr   = 1'b1;
      repeat (2) @(negedge CLK);
      chk("abort_in_rst_valid", {31'd0, inst_valid}, 32'd0);
      chk("abort_in_rst_pc", {7'd0, pc}, 32'd0);
      RST_N = 1'b1;
      @(negedge CLK);
      ovr     = 1'b0;
      drop_en = 1'b0;
      got_rd  = 0;
      repeat (3) @(negedge CLK);
      chk("abort_valid", {31'd0, inst_valid}, 32'd0);
      chk("abort_inst", inst, 32'd0);
      chk("abort_pc", {7'd0, pc}, 32'd0);
      chk("abort_no_req", req_q.size(), 32'd0);
      push_image();
      pulse_start(1'b0);
      drain(1'b0, 4, "refetch");
      repeat (4) @(negedge CLK);
      chk("refetch_first_addr", req_q.size() > 0 ? {7'd0, req_q[0]} : 32'hFFFF_FFFF, 32'd0);
      chk("refetch_halted", {31'd0, halted}, 32'd1);
      chk("refetch_pc", {7'd0, pc}, 32'd4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction-side producer for the accumulator control unit. It fetches 32-bit instruction words from Memoria and buffers them in a small prefetch queue.
- It presents one word at a time on a valid/ready interface to the control block.
- It detects HLT (opcode 3'b101) so that no word past the halt is fetched. It then parks in a halted state.

Parameters:
- ADDR_W, 25, PC / memory address width; equals the immediate field width inst[24:0].
- RESET_PC, 0, PC value loaded on reset.
- QDEPTH, 2, prefetch queue depth in words; fixed at 2 for this revision.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins fetching from the current PC. Honoured only in IDLE.
- mem_req  out  1  read request strobe; one cycle per request.
- mem_addr  out  ADDR_W  word address; valid while mem_req=1.
- mem_rdata  in  32  returned instruction word.
- mem_rvalid  in  1  mem_rdata valid; arrives 1 or more cycles after mem_req.
- inst  out  32  head-of-queue instruction; field layout opcode[31:29], fonte_a[28:27], dest[26:25], imediato[24:0].
- inst_valid  out  1  inst holds a valid word.
- inst_ready  in  1  control accepts inst this cycle.
- pc  out  ADDR_W  address of the next word to request.
- halted  out  1  HLT has been consumed; fetching has ended.

Behaviour:
- Reset (async, RST_N=0):
  - state=IDLE, pc=RESET_PC, queue empty, no request outstanding.
  - mem_req=0, mem_addr=0, inst=0, inst_valid=0, halted=0.
- States: IDLE, RUN, DRAIN, HALT.
  - IDLE: wait for start. start=1 -> RUN. start is ignored in every other state.
  - RUN: mem_req=1 for one cycle when no request is outstanding AND queue occupancy + outstanding < QDEPTH. mem_addr = pc in that cycle, and pc increments on that edge.
  - At most one request may be outstanding.
  - A mem_rvalid with nothing outstanding is ignored; this covers late data after a reset.
  - On mem_rvalid, mem_rdata is pushed into the queue on that edge. inst_valid may rise no earlier than the following cycle.
  - The first mem_req occurs in the cycle after start.
  - If the pushed word has mem_rdata[31:29]=3'b101 -> DRAIN. No further mem_req is issued; pc is frozen at HLT address+1.
  - DRAIN: the queue empties normally. The handshake inst_valid & inst_ready with inst[31:29]=3'b101 -> HALT.
  - HALT: halted=1 from the cycle after the HLT is accepted. inst_valid=0 and mem_req=0. The only exit is reset.
- Handshake:
  - A transfer occurs when inst_valid & inst_ready are both high at a rising edge; the queue pops on that edge.
  - inst and inst_valid must stay stable until the transfer completes.
  - Push and pop in the same cycle are legal at any occupancy: occupancy stays unchanged and order is preserved.
  - Pushing into a full queue cannot occur, because issuing requires a reserved slot. A push while full is an assertion failure.
- Wrap-around: pc at 2^ADDR_W-1 increments to 0 with no flag.
- Opcode handling: all 8 opcodes pass through unmodified. Only 3'b101 affects fetch.
- Throughput:
  - With 1-cycle memory latency and inst_ready held at 1, the block sustains 1 word per 2 cycles, due to the single-outstanding request limit.
  - Steady-state latency from mem_req to inst_valid is memory latency + 1 cycle.

Decomposition:
- Shared package (also used by control):
  - Opcode constants: OP_ADD=3'b000, OP_SUB=3'b001, OP_DIV=3'b010, OP_MUL=3'b011, OP_MC=3'b100, OP_HLT=3'b101, OP_MR=3'b110, OP_MW=3'b111.
  - Field bit positions: OPC_HI=31, OPC_LO=29, SRC_HI=28, SRC_LO=27, DST_HI=26, DST_LO=25, IMM_HI=24, IMM_LO=0.
  - Source/dest codes: REG_A=2'b00, REG_B=2'b01, REG_ACC=2'b10, REG_ZERO=2'b11.
  - FSM state encoding.
- Sub-module: inst_queue, a 2-entry 32-bit FIFO with push, pop, full, empty, head, and the same CLK/RST_N. inst_fetch owns the FSM, pc and outstanding tracking.

Test Plan:
- Reset, then start=0 for 10 cycles -> mem_req never asserted; pc=0, inst_valid=0, halted=0.
- Memory preloaded with words 0x00000000, 0x20000000, 0x60000000, 0xA0000000; start pulse; 1-cycle latency; inst_ready=1.
  - Required: inst sequence 0x00000000, 0x20000000, 0x60000000, 0xA0000000.
  - Required: no mem_req to address 4; halted=1 one cycle after the 0xA0000000 transfer; pc=4.
- Same memory image with inst_ready=0 for 20 cycles after start.
  - Required: exactly 2 mem_req (addresses 0 and 1); inst=0x00000000 held stable with inst_valid=1.
  - Release inst_ready -> remaining words delivered in order.
- ADDR_W=3, RESET_PC=6, memory holds ADD at 6, 7 and 0, HLT at 1.
  - Required: requests go to addresses 6, 7, 0, 1; halted asserts; final pc=2.
- Assert RST_N=0 while a request to address 2 is outstanding; drive mem_rvalid with 0xDEADBEEF during reset and one cycle after.
  - Required: queue stays empty; inst_valid=0; pc=RESET_PC.
  - A new start refetches from address 0.
